sync_split: RTL and testbench

- Synchronous 4-phase handshake demultiplexer/fork. It is the counterpart of the two-into-one merge block.
- One incoming request channel (ri/ai) is routed to either or both outgoing channels (ro1/ao1, ro2/ao2), according to a select mask captured at request time.
- All asynchronous inputs are resynchronised internally through SYNC_STAGES flip-flop chains.
- A per-phase watchdog flags acknowledges that never arrive.

---
 rtl/sync_split.sv | 152 +++++++++++++++
 tb/tb_sync_split.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sync_split.sv
// One-into-two 4-phase handshake fork: the incoming request is routed to the channels
// selected by sel, and the incoming ack follows the selected channel acks.
module sync_split #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ri,
  input  logic [1:0] sel,
  output logic       ai,
  output logic       ro1,
  input  logic       ao1,
  output logic       ro2,
  input  logic       ao2,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    ACKED   = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  // Stage 0 samples the raw pins; stage SYNC_STAGES-1 feeds the FSM. Bits are {ao2, ao1, ri}.
  logic [SYNC_STAGES-1:0][2:0] sync_reg;
  logic ri_s, ao1_s, ao2_s;

  state_t           state_reg, state_next;
  logic [1:0]       mask_reg, mask_next;
  logic             ai_reg, ai_next;
  logic             ro1_reg, ro1_next;
  logic             ro2_reg, ro2_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             acks_high, acks_low;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], {ao2, ao1, ri}};
    end
  end

  assign ri_s  = sync_reg[SYNC_STAGES-1][0];
  assign ao1_s = sync_reg[SYNC_STAGES-1][1];
  assign ao2_s = sync_reg[SYNC_STAGES-1][2];

  // Acks of unselected channels are masked out so spurious activity there is invisible.
  assign acks_high = (ao1_s || !mask_reg[0]) && (ao2_s || !mask_reg[1]);
  assign acks_low  = (!ao1_s || !mask_reg[0]) && (!ao2_s || !mask_reg[1]);

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    ai_next    = ai_reg;
    ro1_next   = ro1_reg;
    ro2_next   = ro2_reg;
    case (state_reg)
      IDLE: begin
        if (ri_s) begin
          mask_next = sel;
          if (sel != 2'b00) begin
            ro1_next   = sel[0];
            ro2_next   = sel[1];
            state_next = REQ;
          end else begin
            ai_next    = 1'b1;
            state_next = ACKED;
          end
        end
      end
      REQ: begin
        if (acks_high) begin
          ai_next    = 1'b1;
          state_next = ACKED;
        end
      end
      ACKED: begin
        if (!ri_s) begin
          ro1_next = 1'b0;
          ro2_next = 1'b0;
          if (mask_reg == 2'b00) begin
            ai_next    = 1'b0;
            state_next = IDLE;
          end else begin
            state_next = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (acks_low) begin
          ai_next    = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        ai_next    = 1'b0;
        ro1_next   = 1'b0;
        ro2_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Watchdog: restarts on every state change, counts only while waiting on channel acks.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if ((state_reg == REQ || state_reg == RELEASE) && cnt_reg != '1) begin
      cnt_next = cnt_reg + 1'b1;
    end
    err_next = err_reg;
    if (TIMEOUT_CYCLES != 0 && cnt_next == TIMEOUT_VAL) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      mask_reg  <= 2'b00;
      ai_reg    <= 1'b0;
      ro1_reg   <= 1'b0;
      ro2_reg   <= 1'b0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      ai_reg    <= ai_next;
      ro1_reg   <= ro1_next;
      ro2_reg   <= ro2_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  assign ai   = ai_reg;
  assign ro1  = ro1_reg;
  assign ro2  = ro2_reg;
  assign busy = (state_reg != IDLE);
  assign err  = err_reg;

endmodule

// File: tb/tb_sync_split.sv
// Randomized bench for sync_split: each handshake's expected waveform is derived from
// the 3-cycle input-to-output latency and the route mask captured at request time.
module tb_sync_split;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ri = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       ao1 = 1'b0;
  logic       ao2 = 1'b0;
  logic       ai, ro1, ro2, busy, err;

  logic       reset_n_w = 1'b0;
  logic       ri_w = 1'b0;
  logic [1:0] sel_w = 2'b00;
  logic       ao1_w = 1'b0;
  logic       ao2_w = 1'b0;
  logic       ai_w, ro1_w, ro2_w, busy_w, err_w;

  sync_split dut (
    .clk(clk), .reset_n(reset_n), .ri(ri), .sel(sel), .ai(ai),
    .ro1(ro1), .ao1(ao1), .ro2(ro2), .ao2(ao2), .busy(busy), .err(err)
  );

  sync_split #(.TIMEOUT_CYCLES(8)) dut_w (
    .clk(clk), .reset_n(reset_n_w), .ri(ri_w), .sel(sel_w), .ai(ai_w),
    .ro1(ro1_w), .ao1(ao1_w), .ro2(ro2_w), .ao2(ao2_w), .busy(busy_w), .err(err_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  // Runs one full handshake starting just after the current edge. Channel acks rise d* cycles
  // after ro rises and fall f* cycles after ro falls; ri drops r cycles after ai rises.
  task automatic run_txn(input logic [1:0] s, input int d1, input int d2, input int r,
                         input int f1, input int f2, input int gap, input bit tog);
    int t0, ro_rise, ro_fall, a1r, a2r, a1f, a2f, ai_rise, ai_fall, ri_fall, last;
    logic sp1, sp2;
    t0 = cyc;
    sel = s;
    ri = 1'b1;
    ro_rise = t0 + 3;
    a1r = ro_rise + d1;
    a2r = ro_rise + d2;
    last = 0;
    if (s[0] && a1r > last) last = a1r;
    if (s[1] && a2r > last) last = a2r;
    ai_rise = (s == 2'b00) ? t0 + 3 : last + 3;
    ri_fall = ai_rise + r;
    ro_fall = ri_fall + 3;
    a1f = ro_fall + f1;
    a2f = ro_fall + f2;
    last = 0;
    if (s[0] && a1f > last) last = a1f;
    if (s[1] && a2f > last) last = a2f;
    ai_fall = (s == 2'b00) ? ri_fall + 3 : last + 3;
    sp1 = 1'($urandom);
    sp2 = 1'($urandom);
    $display("txn sel=%b d=%0d/%0d r=%0d f=%0d/%0d gap=%0d start=%0d", s, d1, d2, r, f1, f2, gap, t0);
    for (int n = t0; n < ai_fall + gap; n++) begin
      if (n == ai_rise) begin
        sp1 = ~sp1;
        sp2 = ~sp2;
      end
      ri  = (n < ri_fall);
      ao1 = s[0] ? (n >= a1r && n < a1f) : sp1;
      ao2 = s[1] ? (n >= a2r && n < a2f) : sp2;
      if (tog && n == t0 + 4) sel = 2'($urandom);
      @(negedge clk);
      chk("ro1", ro1, s[0] && n >= ro_rise && n < ro_fall);
      chk("ro2", ro2, s[1] && n >= ro_rise && n < ro_fall);
      chk("ai", ai, n >= ai_rise && n < ai_fall);
      chk("busy", busy, n >= t0 + 3 && n < ai_fall);
      chk("err", err, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int k, e;
    ri = 1'b1;
    sel = 2'b11;
    ri_w = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ai", ai, 1'b0);
      chk("rst_ro1", ro1, 1'b0);
      chk("rst_ro2", ro2, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    reset_n_w = 1'b1;

    run_txn(2'b11, 2, 3, 1, 1, 2, 0, 1'b0);
    run_txn(2'b01, 5, 0, 2, 5, 0, 2, 1'b0);
    run_txn(2'b11, 0, 10, 1, 0, 10, 2, 1'b0);
    run_txn(2'b00, 0, 0, 3, 0, 0, 2, 1'b0);
    for (int i = 0; i < 20; i++)
      run_txn(2'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 3),
              $urandom_range(0, 6), $urandom_range(0, 6), 0, 1'b1);
    for (int i = 0; i < 20; i++)
      run_txn(2'($urandom), $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 4),
              $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 3), 1'($urandom));
    sel = 2'b00;

    // Watchdog instance: channel 2 selected, its ack withheld well past 8 cycles.
    sel_w = 2'b10;
    ao1_w = 1'b1;
    ri_w = 1'b1;
    k = 0;
    while (ro2_w !== 1'b1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wd_ro2_rise", ro2_w, 1'b1);
    chk("wd_ro2_latency", k == 3, 1'b1);
    e = cyc;
    sel_w = 2'b01;
    for (int n = e; n < e + 12; n++) begin
      $display("wd cycle %0d err=%b", n - e, err_w);
      chk("wd_err", err_w, n >= e + 8);
      chk("wd_ai", ai_w, 1'b0);
      chk("wd_ro1", ro1_w, 1'b0);
      @(posedge clk);
      #1;
    end
    ao2_w = 1'b1;
    for (int m = 0; m < 6; m++) begin
      chk("wd_late_ai", ai_w, m >= 3);
      chk("wd_err_hold", err_w, 1'b1);
      @(posedge clk);
      #1;
    end
    ri_w = 1'b0;
    for (int m = 0; m < 6; m++) begin
      chk("wd_ro2_fall", ro2_w, m < 3);
      chk("wd_ai_held", ai_w, 1'b1);
      @(posedge clk);
      #1;
    end
    ao2_w = 1'b0;
    for (int m = 0; m < 6; m++) begin
      chk("wd_ai_fall", ai_w, m < 3);
      chk("wd_busy", busy_w, m < 3);
      chk("wd_err_sticky", err_w, 1'b1);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
